// File: rtl/sample_packer_if.sv
// Capture-memory write port: packed word, byte mask and valid/ready handshake.
interface sample_packer_if;
    logic        writeValid;
    logic [31:0] writeData;
    logic [3:0]  writeMask;
    logic        writeReady;

    modport master (output writeValid, writeData, writeMask, input writeReady);
    modport slave  (input writeValid, writeData, writeMask, output writeReady);
endinterface

// File: rtl/sample_packer.sv
// Packs compacted channel-group samples into 32-bit capture words behind a small FIFO.
// Optional SAMPLE_PACKER_WORDCOUNT_EN adds a saturating count of accepted words.
module sample_packer #(
    parameter int unsigned OBUF_DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [3:0]     disabledGroups,
    input  logic           arm,
    input  logic           flush,
    input  logic           validIn,
    input  logic [31:0]    dataIn,
    sample_packer_if.master writePort,
    output logic           busy,
    output logic           done,
    output logic           overflow
`ifdef SAMPLE_PACKER_WORDCOUNT_EN
    ,
    output logic [31:0]    wordCount
`endif
);

    localparam int unsigned PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(OBUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t          state;
    logic [2:0]      groupCount;
    logic [1:0]      slotLast;
    logic [1:0]      slot;
    logic [31:0]     accum;
    logic            partialPending;

    logic [31:0]     fifoData [OBUF_DEPTH];
    logic [3:0]      fifoMask [OBUF_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]  count;

    logic [2:0]      armWidth;
    logic            armAccept;
    logic [31:0]     laneMask;
    logic [4:0]      shiftBits;
    logic [31:0]     accumNext;
    logic [3:0]      wordMask;
    logic [2:0]      partialBytes;
    logic [3:0]      partialMask;
    logic            pushReq;
    logic [31:0]     pushWord;
    logic [3:0]      pushMask;
    logic            popReq;
    logic            pushAccept;
    logic            fifoNotEmpty;

    always_comb begin
        armWidth = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            armWidth = armWidth + {2'b00, ~disabledGroups[i]};
        end
    end

    assign armAccept = (state == IDLE) && arm && (armWidth != 3'd0);

    always_comb begin
        laneMask = '1;
        unique case (groupCount)
            3'd1:    laneMask = 32'h0000_00FF;
            3'd2:    laneMask = 32'h0000_FFFF;
            3'd3:    laneMask = 32'h00FF_FFFF;
            default: laneMask = '1;
        endcase
    end

    // Only one- and two-group captures hold more than one sample per word.
    always_comb begin
        shiftBits = '0;
        if (groupCount == 3'd1) begin
            shiftBits = {slot, 3'b000};
        end else if (groupCount == 3'd2) begin
            shiftBits = {slot[0], 4'b0000};
        end
    end

    assign accumNext = accum | ((dataIn & laneMask) << shiftBits);
    assign wordMask  = (groupCount == 3'd3) ? 4'b0111 : 4'b1111;

    always_comb begin
        partialBytes = '0;
        if (groupCount == 3'd1) begin
            partialBytes = {1'b0, slot};
        end else if (groupCount == 3'd2) begin
            partialBytes = {1'b0, slot[0], 1'b0};
        end
    end

    always_comb begin
        partialMask = '0;
        unique case (partialBytes)
            3'd1:    partialMask = 4'b0001;
            3'd2:    partialMask = 4'b0011;
            3'd3:    partialMask = 4'b0111;
            default: partialMask = '0;
        endcase
    end

    always_comb begin
        pushReq  = 1'b0;
        pushWord = accumNext;
        pushMask = wordMask;
        if (state == RUN && validIn && slot == slotLast) begin
            pushReq = 1'b1;
        end else if (state == FLUSH && partialPending) begin
            pushReq  = 1'b1;
            pushWord = accum;
            pushMask = partialMask;
        end
    end

    assign fifoNotEmpty = (count != '0);
    assign popReq       = fifoNotEmpty && writePort.writeReady;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign pushAccept   = pushReq && ((count != FULL_COUNT) || popReq);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            groupCount     <= '0;
            slotLast       <= '0;
            slot           <= '0;
            accum          <= '0;
            partialPending <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pushReq && !pushAccept) begin
                overflow <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (armAccept) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        groupCount <= armWidth;
                        slotLast   <= (armWidth == 3'd1) ? 2'd3 :
                                      (armWidth == 3'd2) ? 2'd1 : 2'd0;
                        slot       <= '0;
                        accum      <= '0;
                        overflow   <= 1'b0;
                    end
                end
                RUN: begin
                    if (validIn) begin
                        if (slot == slotLast) begin
                            slot  <= '0;
                            accum <= '0;
                        end else begin
                            slot  <= slot + 2'd1;
                            accum <= accumNext;
                        end
                    end
                    if (flush) begin
                        state          <= FLUSH;
                        partialPending <= validIn ? (slot != slotLast) : (slot != 2'd0);
                    end
                end
                FLUSH: begin
                    if (partialPending) begin
                        partialPending <= 1'b0;
                        slot           <= '0;
                        accum          <= '0;
                    end else if (!fifoNotEmpty) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushAccept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popReq) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({pushAccept, popReq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (pushAccept) begin
            fifoData[wrPtr] <= pushWord;
            fifoMask[wrPtr] <= pushMask;
        end
    end

    // Storage is not reset, so the head is gated to keep the bus at zero when empty.
    assign writePort.writeValid = fifoNotEmpty;
    assign writePort.writeData  = fifoNotEmpty ? fifoData[rdPtr] : '0;
    assign writePort.writeMask  = fifoNotEmpty ? fifoMask[rdPtr] : '0;

`ifdef SAMPLE_PACKER_WORDCOUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wordCount <= '0;
        end else if (armAccept) begin
            wordCount <= '0;
        end else if (popReq && (wordCount != '1)) begin
            wordCount <= wordCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_packer.sv
// Randomized scoreboard bench for sample_packer against a sample-queue reference model.
module tb_sample_packer;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset_n;
    logic [3:0]  disabledGroups;
    logic        arm;
    logic        flush;
    logic        validIn;
    logic [31:0] dataIn;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef SAMPLE_PACKER_WORDCOUNT_EN
    logic [31:0] wordCount;
`endif

    sample_packer_if bus ();

    sample_packer #(.OBUF_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .disabledGroups (disabledGroups),
        .arm            (arm),
        .flush          (flush),
        .validIn        (validIn),
        .dataIn         (dataIn),
        .writePort      (bus),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
`ifdef SAMPLE_PACKER_WORDCOUNT_EN
        ,
        .wordCount      (wordCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects samples per word and tracks FIFO occupancy.
    typedef enum {M_IDLE, M_RUN, M_FLUSH} mstate_t;
    mstate_t     mState   = M_IDLE;
    int          mW       = 0;
    int          mRatio   = 1;
    logic [31:0] mSamples [$];
    logic [35:0] expQ     [$];
    int          mOcc     = 0;
    bit          mOvf     = 0;
    bit          mDone    = 0;
    bit          mPartial = 0;
    int unsigned mWords   = 0;

    function automatic logic [31:0] packSamples();
        logic [31:0] w = '0;
        for (int i = 0; i < mSamples.size(); i++) begin
            w = w | (mSamples[i] << (8 * mW * i));
        end
        return w;
    endfunction

    function automatic logic [31:0] laneOf(input logic [31:0] d, input int w);
        if (w >= 4) return d;
        return d & ((32'h1 << (8 * w)) - 32'h1);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mState = M_IDLE; mOcc = 0; mOvf = 0; mDone = 0; mPartial = 0; mWords = 0;
            mW = 0; mRatio = 1;
            mSamples.delete();
            expQ.delete();
        end else begin
            bit          pop;
            bit          have;
            logic [31:0] word;
            logic [3:0]  mask;
            int          occ0;
            int          zeros;
            occ0  = mOcc;
            pop   = (occ0 > 0) && bus.writeReady;
            have  = 0;
            word  = '0;
            mask  = '0;
            mDone = 0;
            if (pop) mWords = (mWords == 32'hFFFF_FFFF) ? mWords : mWords + 1;
            case (mState)
                M_IDLE: begin
                    zeros = 0;
                    for (int i = 0; i < 4; i++) if (!disabledGroups[i]) zeros++;
                    if (arm && zeros > 0) begin
                        mW = zeros;
                        mRatio = (zeros == 1) ? 4 : (zeros == 2) ? 2 : 1;
                        mOvf = 0; mWords = 0;
                        mSamples.delete();
                        mState = M_RUN;
                    end
                end
                M_RUN: begin
                    if (validIn) begin
                        mSamples.push_back(laneOf(dataIn, mW));
                        if (mSamples.size() == mRatio) begin
                            have = 1;
                            word = packSamples();
                            mask = (mW == 3) ? 4'b0111 : 4'b1111;
                            mSamples.delete();
                        end
                    end
                    if (flush) begin
                        mState = M_FLUSH;
                        mPartial = (mSamples.size() > 0);
                    end
                end
                M_FLUSH: begin
                    if (mPartial) begin
                        have = 1;
                        word = packSamples();
                        mask = 4'((1 << (mSamples.size() * mW)) - 1);
                        mSamples.delete();
                        mPartial = 0;
                    end else if (occ0 == 0) begin
                        mState = M_IDLE;
                        mDone = 1;
                    end
                end
                default: mState = M_IDLE;
            endcase
            mOcc = occ0 - (pop ? 1 : 0);
            if (have) begin
                if (occ0 == DEPTH && !pop) begin
                    mOvf = 1;
                end else begin
                    expQ.push_back({mask, word});
                    mOcc++;
                end
            end
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each accepted word.
    always @(negedge clock) begin
        if (reset_n) begin
            check("writeValid", {31'd0, bus.writeValid}, {31'd0, mOcc > 0});
            check("busy", {31'd0, busy}, {31'd0, mState != M_IDLE});
            check("done", {31'd0, done}, {31'd0, mDone});
            check("overflow", {31'd0, overflow}, {31'd0, mOvf});
`ifdef SAMPLE_PACKER_WORDCOUNT_EN
            check("wordCount", wordCount, mWords);
`endif
            if (bus.writeValid && bus.writeReady) begin
                if (expQ.size() == 0) begin
                    nChecks++; nFail++;
                    $display("FAIL unexpected_word: got %h/%b expected none", bus.writeData, bus.writeMask);
                end else begin
                    logic [35:0] e;
                    e = expQ.pop_front();
                    check("writeData", bus.writeData, e[31:0]);
                    check("writeMask", {28'd0, bus.writeMask}, {28'd0, e[35:32]});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic peek();
        #3;
    endtask

    task automatic armWith(input logic [3:0] dg);
        disabledGroups = dg; arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic sample(input logic [31:0] d);
        validIn = 1'b1; dataIn = d;
        cyc();
        validIn = 1'b0;
    endtask

    task automatic waitIdle();
        bus.writeReady = 1'b1;
        flush = 1'b0; validIn = 1'b0; arm = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy && mState == M_IDLE) break;
            cyc();
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        cyc();
    endtask

    initial begin
        reset_n = 1'b0; disabledGroups = 4'hF; arm = 0; flush = 0; validIn = 0; dataIn = '0;
        bus.writeReady = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        peek();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, bus.writeValid}, 32'd0);
        check("reset_data", bus.writeData, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        cyc();

        // One group, four samples; config change mid-run must not matter.
        bus.writeReady = 1'b1;
        armWith(4'b1110);
        disabledGroups = 4'b0000;
        sample(32'hFFFF_FF11); sample(32'h22); sample(32'h33); sample(32'h44);
        peek();
        check("t1_valid", {31'd0, bus.writeValid}, 32'd1);
        check("t1_data", bus.writeData, 32'h4433_2211);
        check("t1_mask", {28'd0, bus.writeMask}, 32'hF);
        flush = 1'b1; cyc(); flush = 1'b0;
        waitIdle();

        // Two groups with a partial flush.
        armWith(4'b1100);
        sample(32'hAAAA); sample(32'hBBBB); sample(32'h1234_CCCC);
        flush = 1'b1; cyc(); flush = 1'b0;
        cyc();
        peek();
        check("t2_data", bus.writeData, 32'h0000_CCCC);
        check("t2_mask", {28'd0, bus.writeMask}, 32'h3);
        waitIdle();
        check("t2_busy", {31'd0, busy}, 32'd0);

        // Overflow: five full words into a four-deep FIFO.
        bus.writeReady = 1'b0;
        armWith(4'b0000);
        for (int i = 0; i < DEPTH + 1; i++) sample(32'hA000_0000 + i);
        peek();
        check("t3_overflow", {31'd0, overflow}, 32'd1);
        check("t3_head", bus.writeData, 32'hA000_0000);
        bus.writeReady = 1'b1;
        repeat (6) cyc();
        flush = 1'b1; cyc(); flush = 1'b0;
        waitIdle();

        // Sample and flush in the same cycle, plus arm-wins-over-flush in IDLE.
        disabledGroups = 4'b0111; arm = 1'b1; flush = 1'b1;
        cyc();
        arm = 1'b0; flush = 1'b0;
        sample(32'h01); sample(32'h02);
        validIn = 1'b1; dataIn = 32'hEE03; flush = 1'b1;
        cyc();
        validIn = 1'b0; flush = 1'b0;
        cyc();
        peek();
        check("t4_data", bus.writeData, 32'h0003_0201);
        check("t4_mask", {28'd0, bus.writeMask}, 32'h7);
        waitIdle();

        // Asynchronous reset between edges with words queued.
        bus.writeReady = 1'b0;
        armWith(4'b0000);
        sample(32'h1); sample(32'h2); sample(32'h3);
        #1 reset_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, bus.writeValid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;
        bus.writeReady = 1'b1;
        sample(32'h55);
        repeat (3) cyc();

        // All groups disabled: arm is ignored.
        armWith(4'b1111);
        peek();
        check("ign_busy", {31'd0, busy}, 32'd0);
        cyc();

        // Randomized captures.
        for (int n = 0; n < 30; n++) begin
            int len;
            disabledGroups = 4'($urandom_range(0, 15));
            arm = 1'b1; flush = 1'($urandom_range(0, 1));
            cyc();
            arm = 1'b0; flush = 1'b0;
            len = $urandom_range(3, 30);
            for (int c = 0; c < len; c++) begin
                validIn        = ($urandom_range(0, 3) != 0);
                dataIn         = $urandom;
                bus.writeReady = ($urandom_range(0, 3) != 0);
                disabledGroups = 4'($urandom_range(0, 15));
                arm            = ($urandom_range(0, 7) == 0);
                cyc();
            end
            arm = 1'b0;
            validIn = 1'($urandom_range(0, 1)); dataIn = $urandom; flush = 1'b1;
            cyc();
            validIn = 1'b0; flush = 1'b0;
            waitIdle();
        end

        repeat (DEPTH + 2) cyc();
        check("leftover_words", expQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
- Sits between the channel-group compaction stage and the capture-memory write port.
- Packs narrow compacted samples into full 32-bit memory words: 4 samples/word with 1 group enabled, 2 samples/word with 2 groups, 1 sample/word with 3 or 4 groups.
- Sequences the capture as IDLE -> RUN -> FLUSH -> IDLE.
- Buffers packed words in a small FIFO behind a valid/ready write handshake.

Parameters:
- OBUF_DEPTH, 4, output word FIFO depth; power of 2, >= 2.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- disabledGroups  input  4  1 = group disabled; latched on arm.
- arm  input  1  single-cycle pulse; starts a capture when IDLE.
- flush  input  1  single-cycle pulse; ends the capture when RUN.
- validIn  input  1  compacted sample valid.
- dataIn  input  32  compacted sample, low-justified.
- writeReady  input  1  memory accepts writeData this cycle.
- writeValid  output  1  FIFO head valid.
- writeData  output  32  FIFO head word.
- writeMask  output  4  byte enables of the FIFO head word.
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse on FLUSH -> IDLE.
- overflow  output  1  sticky; a word was dropped.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, FIFO empty, slot=0, accumulator=0, latched config=0. All outputs 0.
- Config, latched on arm in IDLE:
  - w = number of zero bits in disabledGroups.
  - ratio = 4 if w=1; 2 if w=2; 1 if w=3 or 4.
  - w=0: arm is ignored and the block stays IDLE.
- arm in IDLE -> RUN. Also clears overflow and slot. arm outside IDLE is ignored.
- RUN, validIn=1:
  - dataIn[8w-1:0] is written to accumulator bits [8w*slot +: 8w]; bits above 8w in dataIn are ignored.
  - If slot = ratio-1: push {accumulator incl. this sample, mask=4'b1111} to the FIFO and set slot=0. Otherwise slot+1.
  - w=3 passes 24 bits per word with mask=4'b0111. w=4 passes 32 bits with mask=4'b1111.
- Latency: the word completing at edge N is visible on writeData/writeValid after edge N, i.e. in cycle N+1, when the FIFO was empty.
- FIFO:
  - Pop when writeValid & writeReady.
  - Simultaneous push and pop while full is allowed; there is no drop in that case.
  - Push while full without pop: the word is discarded and overflow is set. The slot still advances and wraps.
- flush in RUN -> FLUSH:
  - If validIn and flush arrive in the same cycle, the sample is taken first.
  - If the resulting slot > 0, a partial word is pushed next cycle. Its mask has the low slot*w bytes set; e.g. w=1, slot=3 gives 4'b0111. Unused accumulator bytes are 0.
  - Overflow rules apply to the partial push.
- FLUSH: validIn is ignored. When the FIFO is empty, state goes to IDLE with a done pulse in the same cycle.
- flush outside RUN is ignored. arm and flush in the same cycle in IDLE: arm wins.
- disabledGroups changes during RUN/FLUSH have no effect until the next arm.
- Accumulator clears after each push; the FIFO retains its contents across captures until drained.

Optional Feature:
- Macro: SAMPLE_PACKER_WORDCOUNT_EN.
- Defined:
  - Adds output wordCount [31:0]: count of words accepted by memory (writeValid & writeReady).
  - Reset to 0 asynchronously; cleared on an accepted arm; saturates at 32'hFFFFFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- 1 group, 4 samples: disabledGroups=4'b1110, arm, then 4 validIn with dataIn=0x11,0x22,0x33,0x44, writeReady=1 -> one word 0x44332211, mask 4'b1111, writeValid 1 cycle after the 4th sample.
- 2 groups partial flush: 4'b1100, samples 0xAAAA,0xBBBB,0xCCCC, then flush -> words 0xBBBBAAAA/1111 and 0x0000CCCC/0011. done pulses after the second is accepted; busy=0 after.
- Overflow: 4'b0000 (w=4), writeReady=0, OBUF_DEPTH+1 samples -> FIFO holds the first 4, the 5th is dropped, overflow=1. Raise writeReady: 4 words drain in order. Next arm clears overflow.
- Simultaneous validIn+flush: w=1 with 2 samples held, 3rd sample arrives with flush -> partial word mask 4'b0111 with 3 bytes.
- Async reset mid-RUN: reset_n low for 1 ns between edges with 3 words queued -> writeValid, busy, overflow drop to 0 immediately. After release, arm required; no stale words emitted.
- Ignored inputs: disabledGroups=4'b1111 plus arm -> busy stays 0. Changing disabledGroups in RUN does not alter packing ratio; with SAMPLE_PACKER_WORDCOUNT_EN, wordCount matches accepted words.
